// File: rtl/mdu_pkg.sv
// mdu_pkg: MD opcode/state types and start decode; madd/maddu decode enabled by MDU_MADD_EN.
package mdu_pkg;
    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8
    } md_op_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    function automatic logic is_md_start(input md_op_t op);
`ifdef MDU_MADD_EN
        return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU};
`else
        return op inside {MULT, MULTU, DIV, DIVU};
`endif
    endfunction

    function automatic logic is_div(input md_op_t op);
        return op inside {DIV, DIVU};
    endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result per MD op; divide by zero holds hi/lo.
// madd/maddu accumulation compiled in only with MDU_MADD_EN.
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_t      op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o
);
    logic [63:0] smul, umul;
    logic [31:0] sq, sr, uq, ur;
    logic        dz;

    assign smul = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign umul = {32'd0, rs_i} * {32'd0, rt_i};
    assign sq   = $signed(rs_i) / $signed(rt_i);
    assign sr   = $signed(rs_i) % $signed(rt_i);
    assign uq   = rs_i / rt_i;
    assign ur   = rs_i % rt_i;
    assign dz   = rt_i == 32'd0;

    always_comb begin
        res_o = {hi_i, lo_i};
        case (op_i)
            MULT:  res_o = smul;
            MULTU: res_o = umul;
            DIV:   res_o = dz ? {hi_i, lo_i} : {sr, sq};
            DIVU:  res_o = dz ? {hi_i, lo_i} : {ur, uq};
`ifdef MDU_MADD_EN
            MADD:  res_o = {hi_i, lo_i} + smul;
            MADDU: res_o = {hi_i, lo_i} + umul;
`endif
            default: res_o = {hi_i, lo_i};
        endcase
    end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MD sequencer with busy countdown, HI/LO ownership and D-stage stall request.
// Optional madd/maddu support via MDU_MADD_EN.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_md_op,
    input  logic        e_start,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    md_op_t        op;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d, res;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    assign op = md_op_t'(e_md_op);

    mdu_arith u_arith (
        .op_i (op),
        .rs_i (e_rs),
        .rt_i (e_rt),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .res_o(res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Result is captured at start so later operand changes cannot affect it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (e_start && is_md_start(op)) begin
                pend_d  = res;
                cnt_d   = is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state_d = BUSY;
            end else if (e_start && op == MTHI) begin
                hi_d = e_rs;
            end else if (e_start && op == MTLO) begin
                lo_d = e_rs;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                {hi_d, lo_d} = pend_q;
                state_d      = IDLE;
            end
        end
    end

    assign busy      = state_q == BUSY;
    assign stall_req = d_md_use & (busy | (e_start & is_md_start(op)));
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (madd checks follow MDU_MADD_EN).
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, e_start, d_md_use;
    logic [3:0]  e_md_op;
    logic [31:0] e_rs, e_rt;
    logic        busy, stall_req, busy1, stall1;
    logic [31:0] hi, lo, hi1, lo1;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_start(e_start),
        .e_rs(e_rs), .e_rt(e_rt), .d_md_use(d_md_use),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    mdu_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_start(e_start),
        .e_rs(e_rs), .e_rt(e_rt), .d_md_use(d_md_use),
        .busy(busy1), .stall_req(stall1), .hi(hi1), .lo(lo1)
    );

    always @(posedge clk)
        if (!reset) assert (!(busy && e_start)) else $error("e_start while busy");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input md_op_t op, input logic [31:0] rs, input logic [31:0] rt);
        e_md_op = op;
        e_rs    = rs;
        e_rt    = rt;
        e_start = 1'b1;
        tick();
        e_start = 1'b0;
        e_md_op = NONE;
    endtask

    task automatic test_reset();
        d_md_use = 1'b1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
        d_md_use = 1'b0;
    endtask

    task automatic test_mult();
        issue(MULT, 32'hFFFFFFFE, 32'd3);
        for (int i = 1; i <= 5; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mult_busy c%0d got=%b exp=1", i, busy); end
            tick();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_done got=%b exp=0", busy); end
        tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        tests++; if (lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
        repeat (6) tick();
        tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin fails++; $display("FAIL mult_hold got=%h", {hi, lo}); end
    endtask

    task automatic test_divu();
        issue(DIVU, 32'd7, 32'd2);
        for (int i = 1; i <= 10; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL divu_busy c%0d got=%b exp=1", i, busy); end
            if (i == 10) begin
                tests++; if (lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL divu_early got=%h exp=fffffffa", lo); end
            end
            tick();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL divu_done got=%b exp=0", busy); end
        tests++; if ({hi, lo} !== {32'd1, 32'd3}) begin fails++; $display("FAIL divu_res got=%h exp=0000000100000003", {hi, lo}); end
    endtask

    task automatic test_div();
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        repeat (10) tick();
        tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        issue(DIV, 32'd5, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL divz_busy c%0d got=%b exp=1", i, busy); end
            tick();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL divz_done got=%b exp=0", busy); end
        tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL divz_hold got=%h exp=fffffffffffffffd", {hi, lo}); end
    endtask

    task automatic test_stall();
        d_md_use = 1'b1;
        e_md_op  = MULT;
        e_rs     = 32'd3;
        e_rt     = 32'd4;
        e_start  = 1'b1;
        #1;
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL stall_start got=%b exp=1", stall_req); end
        tick();
        e_start = 1'b0;
        e_md_op = NONE;
        for (int i = 1; i <= 5; i++) begin
            tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL stall_busy c%0d got=%b exp=1", i, stall_req); end
            tick();
        end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL stall_after got=%b exp=0", stall_req); end
        d_md_use = 1'b0;
        issue(MULT, 32'd3, 32'd4);
        for (int i = 1; i <= 5; i++) begin
            tests++; if (stall_req !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL nouse_stall c%0d stall=%b busy=%b exp=0/1", i, stall_req, busy); end
            tick();
        end
        tests++; if ({hi, lo} !== 64'd12) begin fails++; $display("FAIL stall_res got=%h exp=c", {hi, lo}); end
    endtask

    task automatic test_mt_reset();
        issue(MTLO, 32'h1234, 32'd0);
        tests++; if (lo !== 32'h1234) begin fails++; $display("FAIL mtlo_lo got=%h exp=1234", lo); end
        tests++; if (busy !== 1'b0 || hi !== 32'd0) begin fails++; $display("FAIL mtlo_side busy=%b hi=%h exp=0/0", busy, hi); end
        e_md_op = MTHI;
        e_rs    = 32'hDEAD;
        tick();
        e_md_op = NONE;
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL nostart_hi got=%h exp=0", hi); end
        issue(MTHI, 32'h55, 32'd0);
        issue(DIV, 32'd100, 32'd7);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL rst_mid busy=%b hi=%h lo=%h exp=0", busy, hi, lo); end
        for (int i = 0; i < 12; i++) begin
            tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL rst_ghost c%0d got=%h exp=0", i, {hi, lo}); end
            tick();
        end
    endtask

    task automatic test_madd();
        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'hFFFFFFFF, 32'd0);
        d_md_use = 1'b1;
        e_md_op  = MADDU;
        e_rs     = 32'd1;
        e_rt     = 32'd1;
        e_start  = 1'b1;
        #1;
`ifdef MDU_MADD_EN
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL madd_stall got=%b exp=1", stall_req); end
`else
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL madd_stall got=%b exp=0", stall_req); end
`endif
        tick();
        e_start  = 1'b0;
        e_md_op  = NONE;
        d_md_use = 1'b0;
        for (int i = 1; i <= 5; i++) begin
`ifdef MDU_MADD_EN
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL madd_busy c%0d got=%b exp=1", i, busy); end
`else
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL madd_busy c%0d got=%b exp=0", i, busy); end
`endif
            tick();
        end
`ifdef MDU_MADD_EN
        tests++; if ({hi, lo} !== {32'd1, 32'd0}) begin fails++; $display("FAIL madd_res got=%h exp=0000000100000000", {hi, lo}); end
`else
        tests++; if ({hi, lo} !== {32'd0, 32'hFFFFFFFF}) begin fails++; $display("FAIL madd_res got=%h exp=00000000ffffffff", {hi, lo}); end
`endif
    endtask

    task automatic test_n1();
        issue(MULT, 32'd6, 32'd7);
        tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL n1_busy got=%b exp=1", busy1); end
        tick();
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL n1_done got=%b exp=0", busy1); end
        tests++; if (lo1 !== 32'd42 || hi1 !== 32'd0) begin fails++; $display("FAIL n1_res hi=%h lo=%h exp=0/2a", hi1, lo1); end
        repeat (5) tick();
        tests++; if (lo !== 32'd42 || busy !== 1'b0) begin fails++; $display("FAIL n1_main lo=%h busy=%b exp=2a/0", lo, busy); end
    endtask

    initial begin
        reset    = 1'b1;
        e_start  = 1'b0;
        e_md_op  = NONE;
        e_rs     = '0;
        e_rt     = '0;
        d_md_use = 1'b0;
        repeat (2) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_mult();
        test_divu();
        test_div();
        test_stall();
        test_mt_reset();
        test_madd();
        test_n1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
